// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: state encoding,
// default core count and a small modulo helper used by the winner search.
package bus_arb_pkg;

  // Number of requesting cores when the instantiating level does not override it.
  localparam int N_MASTERS_DEFAULT = 4;

  // Raw state encodings. Software-visible through the debug state port.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANTED = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANTED = ST_GRANTED,
    RELEASE = ST_RELEASE
  } arb_state_e;

  // (base + off) wrapped into 0..n-1; base is always a legal index.
  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin winner search: rotate the request vector so the
// core after `last` sits at bit 0, take the lowest set bit, rotate back.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         valid_o,
  output logic [W-1:0] winner_o
);

  logic [N-1:0] rot;
  logic [W-1:0] src_idx;
  int           off;

  // Rotate: rot[i] is the request of core (last+1+i) mod N.
  always_comb begin
    rot     = '0;
    src_idx = '0;
    for (int i = 0; i < N; i++) begin
      src_idx = W'(wrap_add(int'(last_i), i + 1, N));
      rot[i]  = req_i[src_idx];
    end
  end

  // Priority-encode the rotated vector (lowest offset wins) and unrotate.
  always_comb begin
    off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
      end
    end
    valid_o  = |rot;
    winner_o = W'(wrap_add(int'(last_i), off + 1, N));
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner of one shared bus. Grants one core at a time, holds the
// grant for the whole transaction and then sits in a release phase until
// memory has dropped Ready before the bus may be handed out again.
//
// Request/grant protocol: a core raises Bus_RQ[i] and keeps it high for as
// long as it wants the bus. Bus_GRANT[i] rises one edge after the request is
// sampled at a decision point (IDLE, or RELEASE with Ready low) and stays high
// until the edge that samples Bus_RQ[i] low. There is no preemption; dropping
// RQ is the only way to give the bus back, and requests are only looked at
// when the arbiter is deciding, so a short request while another core owns
// the bus is simply never seen.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEFAULT,
  parameter int OWNER_W   = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] Bus_RQ,
  input  logic                 Bus_Mem_Ready,
  output logic [N_MASTERS-1:0] Bus_GRANT,
  output logic [OWNER_W-1:0]   Bus_Owner,
  output logic                 Bus_Busy,
  output logic [1:0]           dbg_state_o
);

  localparam logic [N_MASTERS-1:0] GRANT_ONE  = N_MASTERS'(1);
  localparam logic [OWNER_W-1:0]   LAST_RESET = OWNER_W'(N_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [OWNER_W-1:0]     last_q,  last_d;
  logic [N_MASTERS-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic                   busy_q,  busy_d;

  logic                   pick_valid;
  logic [OWNER_W-1:0]     pick_idx;
  logic                   owner_rq;

  rr_pick #(
    .N (N_MASTERS),
    .W (OWNER_W)
  ) u_pick (
    .req_i    (Bus_RQ),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  assign owner_rq = Bus_RQ[owner_q];

  // Next-state and next-output decision for the IDLE/GRANTED/RELEASE cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_valid) begin
          grant_d = GRANT_ONE << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        busy_d = 1'b1;
        if (!owner_rq) begin
          grant_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Grant stays off for at least this cycle so the outgoing core's
        // drivers can reach high-Z; Ready high keeps us here.
        grant_d = '0;
        busy_d  = 1'b1;
        if (!Bus_Mem_Ready) begin
          if (pick_valid) begin
            grant_d = GRANT_ONE << pick_idx;
            owner_d = pick_idx;
            last_d  = pick_idx;
            state_d = GRANTED;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LAST_RESET;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign Bus_GRANT   = grant_q;
  assign Bus_Owner   = owner_q;
  assign Bus_Busy    = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin bus arbiter that owns the shared instruction or data bus; one instance per bus. Consumes the per-core `*_Bus_RQ` lines driven by each core's ArbitrationSubModule and returns the matching one-hot `*_Bus_GRANT` lines. Guarantees a single owner at a time, holds the grant for the whole transaction, and inserts a release phase so the bus is not re-granted until memory has dropped Ready.

## Interface
- `N_MASTERS`, default 4: number of requesting cores; legal range 2..16.
- `OWNER_W`, default `$clog2(N_MASTERS)`: width of the owner index; derived, not overridden.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Bus_RQ`  in  N_MASTERS  per-core request; bit i comes from core i's ArbitrationSubModule.
- `Bus_Mem_Ready`  in  1  memory Ready as seen on the shared bus.
- `Bus_GRANT`  out  N_MASTERS  one-hot grant, or all zero; registered.
- `Bus_Owner`  out  OWNER_W  index of the current or most recent owner; registered.
- `Bus_Busy`  out  1  high in GRANTED and RELEASE; registered.

## Operation
- The state machine has three states: IDLE, GRANTED and RELEASE.
- **Round-robin pointer `last`:**
  - Holds the last granted index. Reset value is N_MASTERS-1, so core 0 wins the first arbitration.
  - The search starts at `last+1` and wraps modulo N_MASTERS; the first set `Bus_RQ` bit wins.
- **IDLE:**
  - `Bus_GRANT`=0 and `Bus_Busy`=0.
  - If any `Bus_RQ` bit is set, the winner w is selected. On that edge: `Bus_GRANT`←(1<<w), `Bus_Owner`←w, `last`←w, and the state moves to GRANTED.
- **GRANTED:**
  - The grant is held while `Bus_RQ[Bus_Owner]`=1.
  - Other requests are ignored and stay pending. There is no preemption.
  - When `Bus_RQ[Bus_Owner]`=0: `Bus_GRANT`←0 and the state moves to RELEASE.
- **RELEASE:**
  - `Bus_GRANT`=0 and `Bus_Busy`=1. Minimum stay is one cycle, which gives bus-driver turnaround so outgoing cores reach high-Z.
  - If `Bus_Mem_Ready`=1, the arbiter stays in RELEASE.
  - If `Bus_Mem_Ready`=0 and a request is pending, the arbiter arbitrates directly from RELEASE to GRANTED with the same rule as in IDLE.
  - If `Bus_Mem_Ready`=0 and no request is pending, the state moves to IDLE.
- **Requests:**
  - Sampled only at a decision edge.
  - A request raised and withdrawn while another core owns the bus leaves no trace.
  - A core that re-requests immediately after its release gets the lowest priority, because of `last`.
- **Illegal or unused state encoding:** next state is IDLE and `Bus_GRANT`=0.

## Timing
- **Reset values:** `Bus_GRANT`=0, `Bus_Owner`=0, `Bus_Busy`=0, state IDLE, `last`=N_MASTERS-1.
  - Reset asserted mid-grant clears `Bus_GRANT` on the next edge, regardless of `Bus_RQ` or `Bus_Mem_Ready`.
- **Grant latency:** 1 cycle. A request sampled high at edge k in IDLE gives `Bus_GRANT` high after edge k.
- **Release latency:** 1 cycle. The owner's RQ sampled low at edge k gives `Bus_GRANT` low after edge k.
- **Minimum gap between two grants:** 1 full cycle with `Bus_GRANT`=0, plus any cycles with `Bus_Mem_Ready` high.
- **Simultaneous events:**
  - Owner drops RQ while others request: RELEASE first, then the next owner per round-robin.
  - All N request at once: grants go out in index order starting at `last+1`.
- **Invariant:** `Bus_GRANT` is never more than one-hot, and is never nonzero in RELEASE.

## Structure
- Shared package `bus_arb_pkg`: state encoding localparams (IDLE=2'b00, GRANTED=2'b01, RELEASE=2'b10) and the `N_MASTERS` default.
- The design uses one sub-module, `rr_pick`: a purely combinational rotate / priority-encode / unrotate that takes `Bus_RQ` and `last` and returns a valid flag plus the winner index.
- The FSM, the `last` register and the output registers live in `bus_arbiter_rr`.

## Test plan
All scenarios use N_MASTERS=4.
- **Reset:** hold `reset` for 2 cycles with `Bus_RQ`=1111 → `Bus_GRANT`=0000, `Bus_Owner`=0, `Bus_Busy`=0. The first edge after reset release gives `Bus_GRANT`=0001.
- **Single transaction:**
  - Stimulus: `Bus_RQ`=0100, then `Bus_Mem_Ready` pulses high for 2 cycles, then RQ drops. Mem_Ready stays high 1 more cycle, then goes low.
  - Required: `Bus_GRANT`=0100 one cycle after RQ. `Bus_GRANT`=0000 one cycle after RQ drops. `Bus_Busy` stays high until the edge after Mem_Ready falls.
- **Fairness:** `Bus_RQ`=1111, with each owner dropping RQ 3 cycles after its grant and re-raising it 1 cycle later → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one zero-grant cycle between consecutive grants.
- **Ready stall:** after core 1 releases, hold `Bus_Mem_Ready`=1 for 5 cycles with `Bus_RQ`=1000 → `Bus_GRANT` stays 0000 for those 5 cycles. `Bus_GRANT`=1000 on the first edge where Mem_Ready is sampled low.
- **Mid-grant reset:** core 2 holds the grant and `reset` pulses for 1 cycle → the next edge gives `Bus_GRANT`=0000 and `Bus_Owner`=0. With `Bus_RQ`=0100 still high, the grant is re-issued to core 2 one cycle after reset deasserts.
- **No preemption / transient request:** core 0 owns the bus; core 3 raises RQ for 2 cycles, then drops it → core 3 is never granted, and `Bus_GRANT` stays 0001 until core 0 drops RQ.
